// File: rtl/h14tx_period_ctrl.sv
// HDMI 1.4 TX period controller: maps the timing generator's period onto per-channel encoder selects.
// Optional island protocol checker is enabled by defining H14TX_ISLAND_CHECK_EN.
package h14tx_pkg;
  typedef logic [2:0] period_t;
  localparam period_t P_CONTROL = 3'd0;
  localparam period_t P_VPRE    = 3'd1;
  localparam period_t P_VGUARD  = 3'd2;
  localparam period_t P_VACTIVE = 3'd3;
  localparam period_t P_DPRE    = 3'd4;
  localparam period_t P_DGUARD  = 3'd5;
  localparam period_t P_ISLAND  = 3'd6;
endpackage

module h14tx_period_ctrl
  import h14tx_pkg::*;
#(
  parameter int PacketCycles = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  period_t          period,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [23:0]      rgb,
  input  logic             isl_valid,
  input  logic [7:0]       isl_data,
  input  logic             isl_ch0b2,
  output logic             isl_ready,
  output logic [2:0][1:0]  enc_mode,
  output logic [2:0][7:0]  enc_data,
  output logic [2:0][1:0]  enc_ctrl,
  output logic             isl_first,
  output logic             err
);

  localparam int CntW = (PacketCycles > 1) ? $clog2(PacketCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PacketCycles - 1);

  logic [CntW-1:0] cnt;
  logic            island;
  logic            first_c;
  logic [1:0]      sync;
  logic [2:0][1:0] mode_d;
  logic [2:0][7:0] data_d;
  logic [2:0][1:0] ctrl_d;

  assign island    = (period == P_ISLAND);
  assign first_c   = island && (cnt == '0);
  assign isl_ready = island;
  assign sync      = {vsync, hsync};

  // Packet cycle counter; wrapping gives back-to-back packets with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (!island)        cnt <= '0;
    else if (cnt == CntLast) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  always_comb begin
    mode_d = '0;
    data_d = '0;
    ctrl_d = '0;
    case (period)
      P_VPRE: begin
        ctrl_d[0] = sync;
        ctrl_d[1] = 2'b01;
      end
      P_DPRE: begin
        ctrl_d[0] = sync;
        ctrl_d[1] = 2'b01;
        ctrl_d[2] = 2'b01;
      end
      P_VGUARD: begin
        mode_d    = {2'd3, 2'd3, 2'd3};
        data_d[0] = 8'h01;
        data_d[2] = 8'h01;
      end
      P_VACTIVE: begin
        mode_d = {2'd1, 2'd1, 2'd1};
        data_d = {rgb[23:16], rgb[15:8], rgb[7:0]};
      end
      P_DGUARD: begin
        mode_d    = {2'd3, 2'd3, 2'd2};
        data_d[0] = {4'h0, 2'b11, sync};
      end
      P_ISLAND: begin
        mode_d    = {2'd2, 2'd2, 2'd2};
        data_d[0] = {4'h0, ~first_c, isl_ch0b2, sync};
        data_d[1] = {4'h0, isl_data[3:0]};
        data_d[2] = {4'h0, isl_data[7:4]};
      end
      // Control and any unassigned encoding
      default: ctrl_d[0] = sync;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_mode  <= '0;
      enc_data  <= '0;
      enc_ctrl  <= '0;
      isl_first <= 1'b0;
    end else begin
      enc_mode  <= mode_d;
      enc_data  <= data_d;
      enc_ctrl  <= ctrl_d;
      isl_first <= first_c;
    end
  end

`ifdef H14TX_ISLAND_CHECK_EN
  logic err_q;
  // cnt != 0 outside an island means the previous island stopped mid-packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         err_q <= 1'b0;
    else if ((island && !isl_valid) || (!island && cnt != '0)) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic unused_isl_valid;
  assign unused_isl_valid = isl_valid;
  assign err = 1'b0;
`endif

endmodule

// File: doc/h14tx_period_ctrl.md
H14TX_PERIOD_CTRL -- requirements
Module: h14tx_period_ctrl

Interface
REQ-001 SHALL have parameter PacketCycles, default 32: data-island packet length in pixel clocks.
REQ-002 SHALL have port clk  input  1  pixel clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port period  input  period_t  current period from the timing generator (Control, VideoPreamble, VideoGuard, VideoActive, DataPreamble, DataGuard, DataIsland).
REQ-005 SHALL have port hsync  input  1  horizontal sync, cycle-aligned with period.
REQ-006 SHALL have port vsync  input  1  vertical sync, cycle-aligned with period.
REQ-007 SHALL have port rgb  input  24  pixel {R,G,B}, valid during VideoActive.
REQ-008 SHALL have port isl_valid  input  1  upstream island nibble valid.
REQ-009 SHALL have port isl_data  input  8  {ch2[3:0], ch1[3:0]} TERC4 nibbles for the current island cycle.
REQ-010 SHALL have port isl_ch0b2  input  1  ch0 bit2 (header bit) for the current island cycle.
REQ-011 SHALL have port isl_ready  output  1  consume strobe; high in each cycle period==DataIsland.
REQ-012 SHALL have port enc_mode  output  3x2  per-channel encoder select: 0 control, 1 video, 2 TERC4, 3 guard.
REQ-013 SHALL have port enc_data  output  3x8  per-channel payload (video byte or TERC4 nibble in [3:0]).
REQ-014 SHALL have port enc_ctrl  output  3x2  per-channel control bits {c1,c0}.
REQ-015 SHALL have port isl_first  output  1  first cycle of a packet, registered.
REQ-016 SHALL have port err  output  1  sticky protocol error (see Configuration).

Function
REQ-017 SHALL register all outputs except isl_ready; output latency exactly 1 clk from period/hsync/vsync/rgb/isl_*.
REQ-018 SHALL drive isl_ready combinationally as (period==DataIsland).
REQ-019 Control: all enc_mode=0; ch0 ctrl={vsync,hsync}; ch1,ch2 ctrl=00.
REQ-020 VideoPreamble: enc_mode=0; ch0 ctrl={vsync,hsync}; ch1 ctrl=01; ch2 ctrl=00 (CTL3..0=0001).
REQ-021 DataPreamble: enc_mode=0; ch0 ctrl={vsync,hsync}; ch1 ctrl=01; ch2 ctrl=01 (CTL3..0=0101).
REQ-022 VideoGuard: enc_mode ch0=3,ch1=3,ch2=3; enc_data ch0=0x01, ch1=0x00, ch2=0x01 (encoder selects guard word by index).
REQ-023 DataGuard: enc_mode ch0=2 with nibble {1,1,vsync,hsync}; ch1,ch2 enc_mode=3, enc_data=0x00.
REQ-024 VideoActive: enc_mode=1 all; enc_data ch2=R, ch1=G, ch0=B.
REQ-025 DataIsland: enc_mode=2 all; ch0 nibble={~isl_first_comb, isl_ch0b2, vsync, hsync}; ch1=isl_data[3:0]; ch2=isl_data[7:4].
REQ-026 SHALL keep a log2(PacketCycles)-bit cycle counter: cleared outside DataIsland, increments each DataIsland cycle, wraps PacketCycles-1 -> 0.
REQ-027 isl_first_comb SHALL be 1 when period==DataIsland and counter==0; isl_first is its registered copy.
REQ-028 Back-to-back packets SHALL occur by wrap with no gap cycle; island leaving mid-packet SHALL clear counter.
REQ-029 isl_valid low during DataIsland SHALL still output TERC4 with isl_data as sampled (no stall).
REQ-030 Any unlisted period encoding SHALL be treated as Control.

Reset
REQ-031 On rst_n low, asynchronously: enc_mode=0, enc_data=0, enc_ctrl=0, isl_first=0, counter=0, err=0.
REQ-032 First output after release SHALL reflect inputs of the first post-reset edge; reset mid-island restarts the counter at 0.

Configuration
REQ-033 Macro H14TX_ISLAND_CHECK_EN defined: err sets when isl_valid=0 in a DataIsland cycle, or island ends with counter!=0; clears only on reset.
REQ-034 Macro undefined: err tied to 0, no checker logic.

Verification
REQ-035 Control, hsync=1 vsync=0 -> next clk ch0 ctrl=01, enc_mode all 0.
REQ-036 VideoActive rgb=0xA1B2C3 -> next clk enc_data ch2=A1, ch1=B2, ch0=C3, enc_mode all 1.
REQ-037 DataIsland 64 cycles, isl_valid=1 -> isl_first at output cycles 1 and 33; ch0 bit3=0 only there.
REQ-038 DataGuard vsync=1 hsync=0 -> ch0 nibble 0xE, ch1/ch2 enc_mode 3.
REQ-039 With H14TX_ISLAND_CHECK_EN: 20-cycle island -> err=1 after exit; without macro err stays 0.
REQ-040 rst_n low at island cycle 10 -> all outputs 0 immediately; resumed island shows isl_first on its first output cycle.
